// File: rtl/microc_ctrl_pkg.sv
// Shared constants and the control-word type for the microc multicycle controller.
// State codes stay plain 2-bit localparams so older netlists can still match them.
package microc_ctrl_pkg;

   localparam logic [1:0] ST_FETCH = 2'b00;
   localparam logic [1:0] ST_EXEC  = 2'b01;
   localparam logic [1:0] ST_HALT  = 2'b10;

   // The top three opcode bits select ALU and LOADI; the other opcodes are full 6-bit matches.
   localparam logic [2:0] OP_ALU   = 3'b000;
   localparam logic [2:0] OP_LOADI = 3'b001;
   localparam logic [5:0] OP_J     = 6'b010000;
   localparam logic [5:0] OP_JZ    = 6'b010001;
   localparam logic [5:0] OP_JNZ   = 6'b010010;
   localparam logic [5:0] OP_NOP   = 6'b011111;

   typedef struct packed {
      logic       s_inc;
      logic       s_inm;
      logic       we;
      logic       wez;
      logic [2:0] aluop;
   } ctrl_t;

   // Datapath controls outside EXEC: no writes, PC+1.
   localparam ctrl_t CTRL_FETCH = '{s_inc: 1'b1, s_inm: 1'b0, we: 1'b0, wez: 1'b0, aluop: 3'b000};

endpackage

// File: rtl/microc_ctrl_decode.sv
// Pure combinational opcode decoder: (ir, zero) -> datapath control word plus a legal flag.
module microc_ctrl_decode
   import microc_ctrl_pkg::*;
#(
   parameter logic [5:0] HALT_OP = 6'b111111
) (
   input  logic [5:0] ir,
   input  logic       zero,
   output ctrl_t      ctrl,
   output logic       legal
);

   always_comb begin
      ctrl  = CTRL_FETCH;
      legal = 1'b1;
      // HALT_OP keeps the FETCH control word; its pc_we suppression lives in the FSM.
      if (ir != HALT_OP) begin
         case (ir[5:3])
            OP_ALU: begin
               ctrl.we    = 1'b1;
               ctrl.wez   = 1'b1;
               ctrl.aluop = ir[2:0];
            end
            OP_LOADI: begin
               ctrl.we    = 1'b1;
               ctrl.s_inm = 1'b1;
            end
            default: begin
               case (ir)
                  OP_J:    ctrl.s_inc = 1'b0;
                  OP_JZ:   ctrl.s_inc = ~zero;
                  OP_JNZ:  ctrl.s_inc = zero;
                  OP_NOP:  ctrl.s_inc = 1'b1;
                  default: legal      = 1'b0;
               endcase
            end
         endcase
      end
   end

endmodule

// File: rtl/microc_ctrl.sv
// Two-cycle FETCH/EXEC sequencer for the microc datapath with run/pause, halt,
// sticky illegal-opcode flag and a saturating retired-instruction counter.
module microc_ctrl
   import microc_ctrl_pkg::*;
#(
   parameter int         CNT_W   = 16,
   parameter logic [5:0] HALT_OP = 6'b111111
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic             zero,
   input  logic             run,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we,
   output logic             wez,
   output logic [2:0]       ALUOp,
   output logic             pc_we,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [5:0] ir_q;
   logic       exec;
   logic       legal;
   ctrl_t      dec_ctrl;
   ctrl_t      ctrl_out;

   microc_ctrl_decode #(.HALT_OP(HALT_OP)) u_decode (
      .ir    (ir_q),
      .zero  (zero),
      .ctrl  (dec_ctrl),
      .legal (legal)
   );

   assign exec = (state == ST_EXEC);

   // Handshake: run is a level sampled only in FETCH; once EXEC starts it always
   // completes, and pc_we pulses for exactly that EXEC cycle (never for HALT_OP).
   always_comb begin
      state_nxt = ST_FETCH;
      case (state)
         ST_FETCH: state_nxt = run ? ST_EXEC : ST_FETCH;
         ST_EXEC:  state_nxt = (ir_q == HALT_OP) ? ST_HALT : ST_FETCH;
         ST_HALT:  state_nxt = ST_HALT;
         default:  state_nxt = ST_FETCH;
      endcase
   end

   assign ctrl_out = exec ? dec_ctrl : CTRL_FETCH;
   assign s_inc    = ctrl_out.s_inc;
   assign s_inm    = ctrl_out.s_inm;
   assign we       = ctrl_out.we;
   assign wez      = ctrl_out.wez;
   assign ALUOp    = ctrl_out.aluop;
   assign pc_we    = exec && (ir_q != HALT_OP);
   assign halted   = (state == ST_HALT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_FETCH;
         ir_q        <= OP_NOP;
         illegal     <= 1'b0;
         instr_count <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_FETCH)
            ir_q <= Opcode;
         if (exec && !legal)
            illegal <= 1'b1;
         if (exec && (instr_count != {CNT_W{1'b1}}))
            instr_count <= instr_count + CNT_W'(1);
      end
   end

endmodule
